occupancy_counter_bcd: RTL and testbench

- Writer side of the 7-bit occupancy register.
- Takes raw entry/exit pulses, then synchronises and edge-detects them.
- Maintains a saturating up/down count in the range 0..MAX_COUNT and drives reg_data.
- Sequentially converts the count to two BCD digits (shift-add-3) for the display decoders.
- Sits between the sensor inputs and the display path; the >99 overflow detector reads its reg_data output.

---
 rtl/occupancy_counter_bcd.sv | 152 +++++++++++++++
 tb/tb_occupancy_counter_bcd.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/occupancy_counter_bcd.sv
// Occupancy counter: synchronises entry/exit pulses, keeps a saturating 0..MAX_COUNT
// count, and converts it to two BCD digits with a sequential shift-add-3 engine.
module occupancy_counter_bcd #(
  parameter int MAX_COUNT = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_in,
  input  logic       dec_in,
  input  logic       clear,
  output logic [6:0] reg_data,
  output logic       at_max,
  output logic       at_zero,
  output logic       reject,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_units,
  output logic       bcd_valid
);

  localparam int DATA_W = 7;
  localparam logic [DATA_W-1:0] MAX_VAL = DATA_W'(MAX_COUNT);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] c);
    return (c < MAX_VAL) ? c + 1'b1 : c;
  endfunction

  function automatic logic [DATA_W-1:0] sat_dec(input logic [DATA_W-1:0] c);
    return (c != '0) ? c - 1'b1 : c;
  endfunction

  // Stage p0/p1: two-flop synchroniser; p2: previous value for rising-edge detect
  logic inc_p0, inc_p1, inc_p2;
  logic dec_p0, dec_p1, dec_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_p0 <= 1'b0;
      inc_p1 <= 1'b0;
      inc_p2 <= 1'b0;
      dec_p0 <= 1'b0;
      dec_p1 <= 1'b0;
      dec_p2 <= 1'b0;
    end else begin
      inc_p0 <= inc_in;
      inc_p1 <= inc_p0;
      inc_p2 <= inc_p1;
      dec_p0 <= dec_in;
      dec_p1 <= dec_p0;
      dec_p2 <= dec_p1;
    end
  end

  logic inc_evt, dec_evt;
  assign inc_evt = inc_p1 & ~inc_p2;
  assign dec_evt = dec_p1 & ~dec_p2;

  logic [DATA_W-1:0] count_next;
  logic              reject_next;

  always_comb begin
    count_next  = reg_data;
    reject_next = 1'b0;
    if (clear) begin
      count_next = '0;
    end else if (inc_evt && !dec_evt) begin
      count_next  = sat_inc(reg_data);
      reject_next = (reg_data == MAX_VAL);
    end else if (dec_evt && !inc_evt) begin
      count_next  = sat_dec(reg_data);
      reject_next = (reg_data == '0);
    end
  end

  // Count stage: flags registered with the count so they always agree with reg_data
  logic changed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_data <= '0;
      at_max   <= 1'b0;
      at_zero  <= 1'b1;
      reject   <= 1'b0;
      changed  <= 1'b0;
    end else begin
      reg_data <= count_next;
      at_max   <= (count_next == MAX_VAL);
      at_zero  <= (count_next == '0);
      reject   <= reject_next;
      changed  <= (count_next != reg_data);
    end
  end

  state_t            state;
  logic [DATA_W-1:0] shift_sr;
  logic [7:0]        bcd_acc;
  logic [2:0]        bit_cnt;
  logic [7:0]        acc_adj;

  assign acc_adj = {add3(bcd_acc[7:4]), add3(bcd_acc[3:0])};

  // Conversion stage: any count change restarts from LOAD; digits only move in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_sr  <= '0;
      bcd_acc   <= '0;
      bit_cnt   <= '0;
      bcd_tens  <= '0;
      bcd_units <= '0;
      bcd_valid <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (changed) begin
            bcd_valid <= 1'b0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          shift_sr  <= reg_data;
          bcd_acc   <= '0;
          bit_cnt   <= 3'd7;
          bcd_valid <= 1'b0;
          state     <= changed ? LOAD : SHIFT;
        end
        SHIFT: begin
          if (changed) begin
            state <= LOAD;
          end else begin
            {bcd_acc, shift_sr} <= {acc_adj[6:0], shift_sr, 1'b0};
            bit_cnt             <= bit_cnt - 1'b1;
            if (bit_cnt == 3'd1) state <= DONE;
          end
        end
        DONE: begin
          bcd_tens  <= bcd_acc[7:4];
          bcd_units <= bcd_acc[3:0];
          bcd_valid <= ~changed;
          state     <= changed ? LOAD : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_occupancy_counter_bcd.sv
// Directed and randomised bench for occupancy_counter_bcd against an arithmetic
// reference of the count (saturating add/sub) and of its decimal digits (div/mod 10).
module tb_occupancy_counter_bcd;

  localparam int MAX    = 99;
  localparam int K_INC  = 0;
  localparam int K_DEC  = 1;
  localparam int K_BOTH = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inc_in;
  logic       dec_in;
  logic       clear;
  logic [6:0] reg_data;
  logic       at_max;
  logic       at_zero;
  logic       reject;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_units;
  logic       bcd_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int model    = 0;

  always #5 clk = ~clk;

  occupancy_counter_bcd #(.MAX_COUNT(MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_in    (inc_in),
    .dec_in    (dec_in),
    .clear     (clear),
    .reg_data  (reg_data),
    .at_max    (at_max),
    .at_zero   (at_zero),
    .reject    (reject),
    .bcd_tens  (bcd_tens),
    .bcd_units (bcd_units),
    .bcd_valid (bcd_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_reg"}, reg_data, 0);
    check({tag, "_at_zero"}, at_zero, 1);
    check({tag, "_at_max"}, at_max, 0);
    check({tag, "_reject"}, reject, 0);
    check({tag, "_tens"}, bcd_tens, 0);
    check({tag, "_units"}, bcd_units, 0);
    check({tag, "_valid"}, bcd_valid, 1);
  endtask

  task automatic settle(input string tag);
    repeat (12) tick();
    check({tag, "_reg"}, reg_data, model);
    check({tag, "_tens"}, bcd_tens, model / 10);
    check({tag, "_units"}, bcd_units, model % 10);
    check({tag, "_valid"}, bcd_valid, 1);
  endtask

  // One sensor pulse: raised now, applied on the third edge, random hold and gap.
  task automatic pulse(input int kind);
    int prev;
    int rej;
    prev   = model;
    rej    = 0;
    inc_in = (kind != K_DEC);
    dec_in = (kind != K_INC);
    tick();
    tick();
    check("not_yet_applied", reg_data, prev);
    if (kind == K_INC) begin
      if (model < MAX) model++; else rej = 1;
    end else if (kind == K_DEC) begin
      if (model > 0) model--; else rej = 1;
    end
    tick();
    check("count", reg_data, model);
    check("reject", reject, rej);
    check("at_max", at_max, (model == MAX));
    check("at_zero", at_zero, (model == 0));
    tick();
    check("reject_one_cycle", reject, 0);
    repeat ($urandom_range(0, 2)) tick();
    inc_in = 1'b0;
    dec_in = 1'b0;
    repeat ($urandom_range(1, 3)) tick();
    check("held_single_event", reg_data, model);
  endtask

  initial begin
    rst_n  = 1'b0;
    inc_in = 1'b0;
    dec_in = 1'b0;
    clear  = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_reset_outputs("reset");

    // Three 4-cycle inc pulses with exact conversion timing after each change
    for (int p = 1; p <= 3; p++) begin
      inc_in = 1'b1;
      tick();
      tick();
      check("three_pre", reg_data, p - 1);
      tick();
      model = p;
      check("three_count", reg_data, p);
      for (int i = 1; i <= 10; i++) begin
        tick();
        if (i == 1) inc_in = 1'b0;
        if (i < 10) begin
          check("three_valid_low", bcd_valid, 0);
        end else begin
          check("three_valid_high", bcd_valid, 1);
          check("three_tens", bcd_tens, p / 10);
          check("three_units", bcd_units, p % 10);
        end
      end
      check("three_single", reg_data, p);
      repeat (2) tick();
    end

    // Random mix of inc, dec and simultaneous pulses
    repeat (30) begin
      int r;
      r = $urandom_range(0, 99);
      pulse(r < 50 ? K_INC : (r < 85 ? K_DEC : K_BOTH));
    end
    settle("random");

    // Fill to the limit, then one more inc is rejected
    while (model < MAX) pulse(K_INC);
    settle("full");
    pulse(K_INC);
    check("sat_at_max", at_max, 1);
    settle("full_after_reject");

    // Clear, dec at zero, simultaneous inc/dec at 5
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model = 0;
    check("clear_reg", reg_data, 0);
    check("clear_at_zero", at_zero, 1);
    settle("cleared");
    pulse(K_DEC);
    repeat (5) pulse(K_INC);
    pulse(K_BOTH);
    settle("five");

    // Restart: conversion of 42 interrupted by a change to 43
    while (model < 41) pulse(K_INC);
    settle("fortyone");
    inc_in = 1'b1;
    tick();
    tick();
    tick();
    model = 42;
    check("restart_first", reg_data, 42);
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 1) inc_in = 1'b0;
      if (i == 2) inc_in = 1'b1;
      if (i == 6) inc_in = 1'b0;
      if (i == 5) begin
        model = 43;
        check("restart_second", reg_data, 43);
      end
      if (i < 15) begin
        check("restart_valid_low", bcd_valid, 0);
        check("restart_old_digits", {bcd_tens, bcd_units}, 8'h41);
      end else begin
        check("restart_valid_high", bcd_valid, 1);
        check("restart_digits", {bcd_tens, bcd_units}, 8'h43);
      end
    end

    // Clear wins over a pending inc event at 57
    while (model < 57) pulse(K_INC);
    settle("fiftyseven");
    inc_in = 1'b1;
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model = 0;
    check("clear_pending_reg", reg_data, 0);
    check("clear_pending_reject", reject, 0);
    check("clear_pending_zero", at_zero, 1);
    repeat (3) tick();
    inc_in = 1'b0;
    repeat (2) tick();
    check("clear_pending_ignored", reg_data, 0);
    settle("clear_pending");

    // Clear at zero is not a change: no conversion starts
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 11; i++) begin
      tick();
      check("clear_zero_valid", bcd_valid, 1);
    end

    // Asynchronous reset in the middle of a conversion
    inc_in = 1'b1;
    tick();
    tick();
    tick();
    model = 1;
    check("mid_reg", reg_data, 1);
    tick();
    inc_in = 1'b0;
    repeat (4) tick();
    check("mid_valid_low", bcd_valid, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model = 0;
    check_reset_outputs("async_reset");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    check_reset_outputs("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
